mont_exp_ctrl: RTL and testbench
================================

Name: mont_exp_ctrl

Overview:
- Sequencer directly upstream of the Montgomery multiplier. It computes a modular exponentiation in the Montgomery domain using left-to-right square-and-multiply.
- It issues one multiplier operation per square or multiply, passing operand, modulus and result addresses. All operands live in data memory.
- It fetches the exponent and initialises the accumulator through its own LSU port. The LSU port is arbitrated externally against the multiplier's port and the CPU.

Parameters:
- WORDS, 8: operand width in 32-bit words; must match the multiplier.
- EXP_WORDS, 1: exponent width in 32-bit words; exponent bits EBITS = EXP_WORDS*32.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin exponentiation; sampled only in IDLE.
- base_addr  in  32  base operand x*R mod N (Montgomery form).
- one_addr  in  32  R mod N (Montgomery one).
- exp_addr  in  32  exponent, little-endian words.
- N_addr  in  32  modulus.
- res_addr  in  32  accumulator / result buffer, WORDS words.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the result is in memory.
- lsu_ren, lsu_wen  out  1 each  LSU request; held until lsu_done.
- lsu_type  out  2  constant DATA_WORD.
- lsu_addr_base, lsu_addr_offset  out  32 each  LSU address; offset = word index * 4.
- lsu_wdata  out  32  write data.
- lsu_done  in  1  LSU completion; rdata valid in the same cycle.
- lsu_rdata  in  32  read data.
- mm_start  out  1  multiplier start.
- mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr  out  32 each  multiplier addresses.
- mm_done  in  1  multiplier completion pulse.

Behaviour:
- Reset values:
  - State is IDLE.
  - busy, done, lsu_ren, lsu_wen and mm_start are 0.
  - lsu_addr_*, lsu_wdata and all mm_*_addr outputs are 0.
  - Internal exponent register, counters and latched addresses are 0.
- Reset asserted mid-operation aborts immediately. mm_start and the LSU requests drop asynchronously. A multiplier or LSU transaction already in flight is not waited for.
- IDLE:
  - start=1 latches all five addresses and moves to FETCH_EXP.
  - start is ignored in every other state.
- FETCH_EXP:
  - Hold lsu_ren=1 with base=exp_addr, offset=k*4 for k = 0..EXP_WORDS-1.
  - On lsu_done, store word k into exponent slice k and increment k.
  - After the last word go to COPY_RD with word counter w=0.
- COPY_RD:
  - Issue read of one_addr+w*4.
  - On lsu_done, latch rdata into a 32-bit holding register and go to COPY_WR.
- COPY_WR:
  - Issue write of res_addr+w*4 with lsu_wdata = holding register.
  - On lsu_done, increment w.
  - If w was WORDS-1, set bit index j=EBITS-1 and go to SQ_ISSUE; otherwise return to COPY_RD.
  - lsu_ren and lsu_wen are never both high.
- SQ_ISSUE (2 cycles):
  - mm_start=1 for exactly two consecutive cycles.
  - Addresses are A=B=res_addr, N=N_addr, res=res_addr.
  - The two cycles cover the multiplier's two-cycle address capture. Addresses are driven stable from the first start cycle until mm_done.
  - Then go to SQ_WAIT.
- SQ_WAIT:
  - mm_start=0; wait for mm_done.
  - On mm_done: if exponent bit j is 1, go to MUL_ISSUE; else go to NEXT.
- MUL_ISSUE / MUL_WAIT:
  - Same as the square states, but with A=res_addr, B=base_addr.
  - mm_done goes to NEXT.
- NEXT:
  - If j==0, go to FINISH.
  - Else decrement j and go to SQ_ISSUE.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- The first square on R mod N leaves the accumulator unchanged, so leading zero bits are harmless. No leading-zero skip is performed.
- The total number of multiplier operations is EBITS + popcount(exp).
- mm_done is ignored outside the WAIT states.
- lsu_done is ignored outside the FETCH_EXP and COPY states.
- In-place operation (res=A) relies on the multiplier fetching all operands before writing its result.

Test Plan:
- Reset during SQ_WAIT -> busy, mm_start and lsu_ren drop asynchronously; state is IDLE; a later start runs a full, correct sequence.
- EXP_WORDS=1, exp=0x00000005, WORDS=2, multiplier model always responding:
  - Bench counts exactly 34 mm_start sequences (32 squares, 2 muls).
  - The muls follow the squares at bit indices 2 and 0.
  - Each mm_start is high for exactly 2 cycles.
- exp=0 -> only 32 squares are issued; memory at res_addr equals R mod N; done pulses once.
- Copy phase with one_addr words {0x11111111, 0x22222222} and a 3-cycle LSU latency -> res_addr words equal those values, in order, before the first mm_start.
- Full functional check with a real multiplier, N=0xF000000000000001 (WORDS=2), x=3, exp=0x10001:
  - After conversion out of the Montgomery domain, the result equals 3^65537 mod N, computed by the bench reference.
- start pulsed while busy, and a spurious mm_done during COPY_WR -> both are ignored; the sequence and the result are unchanged.

Source files
------------

// File: rtl/mont_exp_ctrl.sv
// Montgomery exponentiation sequencer.
// Computes acc = base^exp with left-to-right square-and-multiply. All operands
// stay in the Montgomery domain. The block first loads the exponent and copies
// R mod N into the result buffer over its LSU port, then issues one multiplier
// operation for each square and each multiply.
module mont_exp_ctrl #(
  parameter int WORDS     = 8,
  parameter int EXP_WORDS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] one_addr,
  input  logic [31:0] exp_addr,
  input  logic [31:0] N_addr,
  input  logic [31:0] res_addr,
  output logic        busy,
  output logic        done,
  output logic        lsu_ren,
  output logic        lsu_wen,
  output logic [1:0]  lsu_type,
  output logic [31:0] lsu_addr_base,
  output logic [31:0] lsu_addr_offset,
  output logic [31:0] lsu_wdata,
  input  logic        lsu_done,
  input  logic [31:0] lsu_rdata,
  output logic        mm_start,
  output logic [31:0] mm_A_addr,
  output logic [31:0] mm_B_addr,
  output logic [31:0] mm_N_addr,
  output logic [31:0] mm_res_addr,
  input  logic        mm_done
);

  localparam int EBITS = EXP_WORDS * 32;
  localparam int KW    = (EXP_WORDS > 1) ? $clog2(EXP_WORDS) : 1;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int JW    = $clog2(EBITS);

  // Word-sized access encoding understood by the LSU.
  localparam logic [1:0]    DATA_WORD = 2'b10;
  localparam logic [KW-1:0] K_LAST    = KW'(EXP_WORDS - 1);
  localparam logic [WW-1:0] W_LAST    = WW'(WORDS - 1);
  localparam logic [JW-1:0] J_TOP     = JW'(EBITS - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH_EXP, COPY_RD, COPY_WR,
    SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [EBITS-1:0] exp_q;
  logic [KW-1:0]   k_q;     // exponent word being fetched
  logic [WW-1:0]   w_q;     // accumulator word being copied
  logic [JW-1:0]   j_q;     // exponent bit being processed
  logic [31:0]     hold_q;  // word in transit from one_addr to res_addr
  logic            iss_q;   // second cycle of a two-cycle mm_start
  logic [31:0]     base_q, one_q, expa_q, n_q, res_q;

  // State register; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: use non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: latched addresses, exponent, counters and holding register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: exp_q is a small flop bank, not a RAM, so it is reset with the rest.
    if (rst) begin
      exp_q  <= '0;
      k_q    <= '0;
      w_q    <= '0;
      j_q    <= '0;
      hold_q <= '0;
      iss_q  <= 1'b0;
      base_q <= '0;
      one_q  <= '0;
      expa_q <= '0;
      n_q    <= '0;
      res_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          base_q <= base_addr;
          one_q  <= one_addr;
          expa_q <= exp_addr;
          n_q    <= N_addr;
          res_q  <= res_addr;
          k_q    <= '0;
          w_q    <= '0;
        end
        FETCH_EXP: if (lsu_done) begin
          for (int i = 0; i < EXP_WORDS; i++)
            if (k_q == KW'(i)) exp_q[i*32 +: 32] <= lsu_rdata;
          k_q <= k_q + 1'b1;
        end
        COPY_RD: if (lsu_done) hold_q <= lsu_rdata;
        COPY_WR: if (lsu_done) begin
          w_q <= w_q + 1'b1;
          if (w_q == W_LAST) j_q <= J_TOP;
        end
        SQ_ISSUE, MUL_ISSUE: iss_q <= ~iss_q;
        NEXT: if (j_q != '0) j_q <= j_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic and outputs decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d         = state_q;
    busy            = (state_q != IDLE) && (state_q != FINISH);
    done            = 1'b0;
    lsu_ren         = 1'b0;
    lsu_wen         = 1'b0;
    lsu_type        = DATA_WORD;
    lsu_addr_base   = '0;
    lsu_addr_offset = '0;
    lsu_wdata       = '0;
    mm_start        = 1'b0;
    mm_A_addr       = '0;
    mm_B_addr       = '0;
    mm_N_addr       = '0;
    mm_res_addr     = '0;

    case (state_q)
      IDLE: if (start) state_d = FETCH_EXP;
      FETCH_EXP: begin
        lsu_ren         = 1'b1;
        lsu_addr_base   = expa_q;
        lsu_addr_offset = 32'(k_q) << 2;
        if (lsu_done && k_q == K_LAST) state_d = COPY_RD;
      end
      COPY_RD: begin
        lsu_ren         = 1'b1;
        lsu_addr_base   = one_q;
        lsu_addr_offset = 32'(w_q) << 2;
        if (lsu_done) state_d = COPY_WR;
      end
      COPY_WR: begin
        lsu_wen         = 1'b1;
        lsu_addr_base   = res_q;
        lsu_addr_offset = 32'(w_q) << 2;
        lsu_wdata       = hold_q;
        if (lsu_done) state_d = (w_q == W_LAST) ? SQ_ISSUE : COPY_RD;
      end
      SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT: begin
        // Addresses stay stable from the first start cycle until mm_done.
        mm_A_addr   = res_q;
        mm_B_addr   = (state_q == MUL_ISSUE || state_q == MUL_WAIT) ? base_q : res_q;
        mm_N_addr   = n_q;
        mm_res_addr = res_q;
        case (state_q)
          SQ_ISSUE: begin
            mm_start = 1'b1;
            if (iss_q) state_d = SQ_WAIT;
          end
          MUL_ISSUE: begin
            mm_start = 1'b1;
            if (iss_q) state_d = MUL_WAIT;
          end
          SQ_WAIT:  if (mm_done) state_d = exp_q[j_q] ? MUL_ISSUE : NEXT;
          default:  if (mm_done) state_d = NEXT;
        endcase
      end
      NEXT:   state_d = (j_q == '0) ? FINISH : SQ_ISSUE;
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl with WORDS=2 and EXP_WORDS=1. The bench provides a
// word memory, an LSU responder with programmable latency, and a 64-bit
// Montgomery multiplier model. A scoreboard queue holds the expected operation
// order.
module tb_mont_exp_ctrl;

  localparam logic [31:0]  BASE_A = 32'h000, ONE_A = 32'h040, EXP_A = 32'h080;
  localparam logic [31:0]  N_A    = 32'h0C0, RES_A = 32'h100;
  localparam logic [63:0]  N_VAL  = 64'hF000_0000_0000_0001;

  typedef struct packed { logic [31:0] a; logic [31:0] b; } op_t;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] base_addr = BASE_A;
  logic        busy, done, lsu_ren, lsu_wen, lsu_done = 1'b0, mm_start, mm_done = 1'b0;
  logic [1:0]  lsu_type;
  logic [31:0] lsu_addr_base, lsu_addr_offset, lsu_wdata, lsu_rdata = '0;
  logic [31:0] mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr;

  logic [31:0] mem [0:127];
  op_t         sb_q [$];
  int          tests = 0, failed = 0;
  int          lsu_lat = 0, lsu_cnt = 0, mm_lat = 2, mm_cnt = 0, mm_ph = 0, mm_len = 0;
  int          seq_cnt = 0;
  bit          spur_arm = 1'b0, snap_pending = 1'b0;
  logic [31:0] snap0, snap1, cap_a, cap_b, cap_n, cap_r;
  logic [63:0] one_m, base_m;

  mont_exp_ctrl #(.WORDS(2), .EXP_WORDS(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .one_addr(ONE_A), .exp_addr(EXP_A), .N_addr(N_A), .res_addr(RES_A),
    .busy(busy), .done(done),
    .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_type(lsu_type),
    .lsu_addr_base(lsu_addr_base), .lsu_addr_offset(lsu_addr_offset), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .mm_start(mm_start), .mm_A_addr(mm_A_addr), .mm_B_addr(mm_B_addr),
    .mm_N_addr(mm_N_addr), .mm_res_addr(mm_res_addr), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] idx(input logic [31:0] addr);
    return addr[8:2];
  endfunction

  function automatic logic [63:0] rd64(input logic [31:0] addr);
    return {mem[idx(addr) + 7'd1], mem[idx(addr)]};
  endfunction

  // a*b*2^-64 mod n, by reducing the product and halving modulo n 64 times.
  function automatic logic [63:0] mont_mul(input logic [63:0] a, b, n);
    logic [127:0] t;
    t = (128'(a) * 128'(b)) % 128'(n);
    for (int i = 0; i < 64; i++) begin
      if (t[0]) t = t + 128'(n);
      t = t >> 1;
    end
    return t[63:0];
  endfunction

  // Plain-domain reference: 3^e mod N_VAL.
  function automatic logic [63:0] modexp3(input logic [31:0] e);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % 128'(N_VAL);
      if (e[i]) r = (r * 128'd3) % 128'(N_VAL);
    end
    return r[63:0];
  endfunction

  // LSU responder: completes after lsu_lat extra cycles, data in the done cycle.
  always @(negedge clk) begin
    lsu_done = 1'b0;
    if (rst) lsu_cnt = 0;
    else if (lsu_ren || lsu_wen) begin
      if (lsu_cnt >= lsu_lat) begin
        check("lsu_excl", 128'(lsu_ren & lsu_wen), 128'(0));
        lsu_done = 1'b1;
        lsu_cnt  = 0;
        if (lsu_ren) lsu_rdata = mem[idx(lsu_addr_base + lsu_addr_offset)];
        else         mem[idx(lsu_addr_base + lsu_addr_offset)] = lsu_wdata;
      end else lsu_cnt++;
    end else lsu_cnt = 0;
  end

  // Multiplier model: checks start length and addresses against the scoreboard.
  always @(negedge clk) begin
    op_t         e;
    logic [63:0] r;
    if (rst) begin
      mm_done = 1'b0;
      mm_ph   = 0;
    end else begin
      mm_done = 1'b0;
      if (spur_arm && lsu_wen) begin
        mm_done  = 1'b1;
        spur_arm = 1'b0;
      end
      case (mm_ph)
        0: if (mm_start) begin
          {cap_a, cap_b, cap_n, cap_r} = {mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr};
          mm_len = 1;
          mm_ph  = 1;
          if (snap_pending) begin
            snap0 = mem[idx(RES_A)];
            snap1 = mem[idx(RES_A) + 7'd1];
            snap_pending = 1'b0;
          end
        end
        1: if (mm_start) mm_len++;
        else begin
          seq_cnt++;
          check("mm_start_len", 128'(mm_len), 128'(2));
          check("sb_nonempty", 128'(sb_q.size() > 0), 128'(1));
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("mm_op_ab", 128'({cap_a, cap_b}), 128'({e.a, e.b}));
            check("mm_op_nr", 128'({cap_n, cap_r}), 128'({N_A, RES_A}));
          end
          mm_cnt = 0;
          mm_ph  = 2;
        end
        default: if (mm_cnt >= mm_lat) begin
          check("mm_addr_stable", {mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr},
                {cap_a, cap_b, cap_n, cap_r});
          r = mont_mul(rd64(cap_a), rd64(cap_b), rd64(cap_n));
          mem[idx(cap_r)]         = r[31:0];
          mem[idx(cap_r) + 7'd1]  = r[63:32];
          mm_done = 1'b1;
          mm_ph   = 0;
        end else mm_cnt++;
      endcase
    end
  end

  task automatic setup(input logic [63:0] one_v, input logic [31:0] e);
    mem[idx(ONE_A)] = one_v[31:0];   mem[idx(ONE_A) + 7'd1] = one_v[63:32];
    mem[idx(BASE_A)] = base_m[31:0]; mem[idx(BASE_A) + 7'd1] = base_m[63:32];
    mem[idx(N_A)] = N_VAL[31:0];     mem[idx(N_A) + 7'd1] = N_VAL[63:32];
    mem[idx(RES_A)] = '0;            mem[idx(RES_A) + 7'd1] = '0;
    mem[idx(EXP_A)] = e;
  endtask

  task automatic push_ops(input logic [31:0] e);
    op_t o;
    for (int j = 31; j >= 0; j--) begin
      o = '{a: RES_A, b: RES_A};
      sb_q.push_back(o);
      if (e[j]) begin
        o = '{a: RES_A, b: BASE_A};
        sb_q.push_back(o);
      end
    end
  endtask

  // Run one exponentiation; called at a negedge.
  task automatic run_exp(input logic [31:0] e, input bit disturb, input bit chk_res);
    int done_cnt, cyc;
    push_ops(e);
    seq_cnt = 0;
    snap_pending = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'(1));
    done_cnt = 0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 30) begin
        start = 1'b1;
        base_addr = 32'hDEAD_0000;
      end else if (disturb && cyc == 31) begin
        start = 1'b0;
        base_addr = BASE_A;
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", 128'(busy), 128'(0));
      end
    end
    check("done_seen", 128'(done_cnt), 128'(1));
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("done_once", 128'(done_cnt), 128'(1));
    check("mm_op_count", 128'(seq_cnt), 128'(32 + $countones(e)));
    check("sb_drained", 128'(sb_q.size()), 128'(0));
    if (chk_res)
      check("result", 128'(mont_mul(rd64(RES_A), 64'd1, N_VAL)), 128'(modexp3(e)));
  endtask

  initial begin
    int  cyc;
    bit  saw;
    one_m  = 64'(((128'd1) << 64) % 128'(N_VAL));
    base_m = 64'(((128'd3) << 64) % 128'(N_VAL));

    repeat (2) @(negedge clk);
    check("rst_ctrl", 128'({busy, done, lsu_ren, lsu_wen, mm_start}), 128'(0));
    check("rst_addr", {lsu_addr_base | lsu_addr_offset | lsu_wdata, mm_A_addr,
                       mm_B_addr | mm_N_addr, mm_res_addr}, 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Reset while waiting on the first square.
    setup(one_m, 32'h5);
    push_ops(32'h5);
    mm_lat = 4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw = 1'b0;
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (mm_start) saw = 1'b1;
      else if (saw) break;
    end
    check("reach_sq_wait", 128'({saw, mm_start}), 128'(2'b10));
    check("busy_before_rst", 128'(busy), 128'(1));
    #2 rst = 1'b1;
    #1 check("async_drop", 128'({busy, mm_start, lsu_ren, lsu_wen}), 128'(0));
    check("rst_idle_addr", 128'(mm_A_addr | mm_res_addr), 128'(0));
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("idle_after_rst", 128'({busy, done, lsu_ren, lsu_wen, mm_start}), 128'(0));

    // exp=5: 32 squares, multiplies after bits 2 and 0.
    mm_lat = 2;
    setup(one_m, 32'h5);
    run_exp(32'h5, 1'b0, 1'b1);

    // exp=0: only squares; R mod N squared stays R mod N.
    setup(one_m, 32'h0);
    run_exp(32'h0, 1'b0, 1'b1);
    check("exp0_res_one", 128'(rd64(RES_A)), 128'(one_m));

    // Copy phase with slow LSU.
    lsu_lat = 2;
    setup({32'h2222_2222, 32'h1111_1111}, 32'h0);
    run_exp(32'h0, 1'b0, 1'b0);
    check("copy_word0", 128'(snap0), 128'(32'h1111_1111));
    check("copy_word1", 128'(snap1), 128'(32'h2222_2222));

    // Full functional check: 3^65537 mod N.
    lsu_lat = 1;
    mm_lat  = 3;
    setup(one_m, 32'h0001_0001);
    run_exp(32'h0001_0001, 1'b0, 1'b1);

    // Same run with a start pulse while busy and a spurious mm_done in COPY_WR.
    setup(one_m, 32'h0001_0001);
    spur_arm = 1'b1;
    run_exp(32'h0001_0001, 1'b1, 1'b1);
    check("spur_delivered", 128'(spur_arm), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
